// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Grant and FSM encodings live here so the top and the bench agree on them.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    I_ACCESS = 2'd1,
    D_ACCESS = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  localparam int DEF_MEM_LATENCY  = 2;
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter timing a fixed-latency RAM access.
// done is high whenever the count has reached zero.
module wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch and data load/store,
// with data priority, a fetch starvation guard and a combinational pc stall.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              protocol_err,
  output state_t            dbg_state
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  // Handshake: a requester raises i_req or d_read_en/d_write_en as a level with
  // address/data stable; requests are sampled only in IDLE, and the matching
  // *_ready is a single-cycle pulse after which the requester may drop or advance.
  state_t        state, next_state;
  gnt_t          gnt_sel;
  logic          grant_valid;
  logic          acc_last;
  logic          acc_done;
  logic          d_any;
  logic          starve_hit;
  logic [SW-1:0] streak;
  logic          unused_addr_bits;

  assign d_any            = d_read_en | d_write_en;
  assign starve_hit       = (STARVE_LIMIT != 0) && i_req && (streak == SW'(STARVE_LIMIT));
  assign stall            = (i_req & ~i_ready) | (d_any & ~d_ready);
  assign dbg_state        = state;
  assign unused_addr_bits = ^i_addr[1:0];

  wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_valid),
    .en       ((state == I_ACCESS) || (state == D_ACCESS)),
    .load_val (CW'(MEM_LATENCY - 1)),
    .done     (acc_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    gnt_sel     = GNT_I;
    acc_last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_any && !starve_hit) begin
          grant_valid = 1'b1;
          gnt_sel     = GNT_D;
          next_state  = D_ACCESS;
        end else if (i_req) begin
          grant_valid = 1'b1;
          gnt_sel     = GNT_I;
          next_state  = I_ACCESS;
        end
      end
      I_ACCESS, D_ACCESS: begin
        if (acc_done) begin
          acc_last   = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      mem_addr     <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_wdata    <= '0;
      protocol_err <= 1'b0;
      streak       <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_valid) begin
        if (gnt_sel == GNT_I) begin
          mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
          mem_read  <= 1'b1;
          mem_write <= 1'b0;
          streak    <= '0;
        end else begin
          mem_addr  <= d_addr;
          mem_read  <= ~d_write_en;
          mem_write <= d_write_en;
          if (d_write_en) mem_wdata <= d_wdata;
          if (d_read_en && d_write_en) protocol_err <= 1'b1;
          // Only a waiting fetch makes a data run count toward starvation.
          if (!i_req) streak <= '0;
          else if (streak != SW'(STARVE_LIMIT)) streak <= streak + 1'b1;
        end
      end
      if (acc_last) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (state == I_ACCESS) begin
          i_ready <= 1'b1;
          i_rdata <= mem_rdata;
        end else begin
          d_ready <= 1'b1;
          if (mem_read) d_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port `ram` between instruction fetch (pc side) and data load/store (ALU result address / byte_demux write data).
- Sequences each access over a fixed-latency memory, returns read data to the winning requester and drives a stall line that freezes the pc while any request is outstanding.
- Data has fixed priority over fetch. A starvation guard forces a fetch grant after a run of consecutive data grants.

Parameters:
- MEM_LATENCY, 2, cycles a RAM access is held active; legal range ≥1.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits; 0 = pure data priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request (level, held until i_ready)
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  one-cycle pulse: i_rdata valid
- i_rdata  out  DATA_W  fetched instruction (registered, holds until next fetch)
- d_read_en  in  1  data read request (level)
- d_write_en  in  1  data write request (level)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data (registered, holds until next data read)
- mem_addr  out  ADDR_W  RAM address
- mem_read  out  1  RAM read enable
- mem_write  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- stall  out  1  pc hold
- protocol_err  out  1  sticky: d_read_en & d_write_en seen at a grant

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs go to 0: i_ready, d_ready, i_rdata, d_rdata, mem_*, protocol_err, streak counter, wait counter.
  - mem_read and mem_write drop immediately, not at the next edge.
- FSM states: IDLE, I_ACCESS, D_ACCESS, RESP.
- IDLE grant decision (d_any = d_read_en|d_write_en):
  - Grant data if d_any, unless i_req and streak==STARVE_LIMIT and STARVE_LIMIT≠0. In that case grant fetch.
  - Otherwise grant fetch if i_req. Otherwise stay in IDLE.
- Registering a grant:
  - mem_addr is loaded at the grant edge. Fetch: {i_addr[ADDR_W-1:2],2'b00}. Data: d_addr unmodified.
  - mem_read or mem_write is set at the grant edge. mem_wdata is set to d_wdata for writes.
  - If both d_read_en and d_write_en are high, the access is a write and protocol_err is set.
- I_ACCESS / D_ACCESS:
  - Last for exactly MEM_LATENCY cycles; the wait counter loads MEM_LATENCY-1 and decrements.
  - mem_* signals stay stable throughout.
  - On the final edge: capture mem_rdata into i_rdata (fetch) or d_rdata (data read). Writes leave d_rdata unchanged.
  - Clear mem_read/mem_write, set i_ready or d_ready, go to RESP.
- RESP:
  - Lasts one cycle with the ready pulse high.
  - Returns to IDLE unconditionally; requests are ignored so the requester can drop or advance.
- Latency: request first seen in IDLE at cycle 0 → ready high in cycle MEM_LATENCY+1. Back-to-back accesses cost MEM_LATENCY+2 cycles each.
- Streak counter:
  - +1 on a data grant while i_req is high (saturates at STARVE_LIMIT).
  - Cleared on any fetch grant, and on a data grant when i_req is low.
- stall = (i_req & ~i_ready) | (d_any & ~d_ready). This is combinational, so the pc advances exactly in the i_ready cycle.
- Requester contract:
  - Address and data are held stable from request until ready.
  - Request signals are sampled only in IDLE; changes during an access are ignored.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, I_ACCESS, D_ACCESS, RESP)
  - grant enum (GNT_I, GNT_D)
  - default MEM_LATENCY and STARVE_LIMIT constants
- One sub-module, wait_counter: loadable down-counter with load, enable and a done flag. Used for the access timer; the streak counter stays inline.

Test Plan:
- Reset: rst=0 with i_req=1 → all outputs 0, stall=1; after release, access starts from IDLE.
- Fetch, MEM_LATENCY=2: i_req at cycle 0, i_addr=0x0000_0013, mem_rdata=0x00500093 →
  - mem_addr=0x10, mem_read high in cycles 1–2
  - i_ready pulse in cycle 3, i_rdata=0x00500093
  - stall high cycles 0–2, low in cycle 3
- Simultaneous i_req and d_read_en at cycle 0 → data access in cycles 1–2, d_ready in cycle 3; fetch granted cycle 4, i_ready in cycle 7.
- Store: d_write_en, d_addr=0x100, d_wdata=0xDEADBEEF →
  - mem_write high for 2 cycles with those values, d_ready pulse
  - d_rdata unchanged
  - repeat with d_read_en also high → write performed, protocol_err=1 until reset
- Starvation, STARVE_LIMIT=2: d_read_en and i_req held continuously → grant order D, D, I, D, D, I.
- Reset mid-access: rst=0 in cycle 1 of a read → mem_read=0 before the next edge, no ready pulse; after release the held request completes normally.
